// File: rtl/mstatus_csr_ctrl.sv
// mstatus_csr_ctrl: machine status register for an M/U-only RISC-V hart.
// Holds MIE, MPIE, MPP, FS, MPRV and TW, and tracks the privilege level.
// It applies trap, MRET and CSR updates, and runs the WFI sleep state machine.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   csr_wen/cmd/wdata mstatus CSR access (01 write, 10 set, 11 clear)
//   trap_valid        trap taken this cycle
//   mret_valid        MRET retires this cycle
//   wfi_valid         WFI retires this cycle
//   irq_pending       wakes a sleeping WFI
//   fs_dirty_set      FP register state was written this cycle
//   prv, dprv         current privilege and effective data privilege
//   mie..sd, mpp, fs  individual mstatus fields
//   mstatus_rdata     architectural read value of mstatus
//   sleeping          core is waiting in WFI
//   illegal_wfi       one-cycle pulse for a WFI trapped by TW
module mstatus_csr_ctrl #(
    parameter bit HAS_FPU = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_wen,
    input  logic [1:0]  csr_cmd,
    input  logic [63:0] csr_wdata,
    input  logic        trap_valid,
    input  logic        mret_valid,
    input  logic        wfi_valid,
    input  logic        irq_pending,
    input  logic        fs_dirty_set,
    output logic [1:0]  prv,
    output logic [1:0]  dprv,
    output logic        mie,
    output logic        mpie,
    output logic        mprv,
    output logic        tw,
    output logic        sd,
    output logic [1:0]  mpp,
    output logic [1:0]  fs,
    output logic [63:0] mstatus_rdata,
    output logic        sleeping,
    output logic        illegal_wfi
);

    localparam logic [1:0] PRV_M = 2'b11;
    localparam logic [1:0] PRV_U = 2'b00;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SLEEP = 1'b1
    } wfi_state_e;

    logic [1:0] prv_q, prv_d;
    logic       mie_q, mie_d;
    logic       mpie_q, mpie_d;
    logic [1:0] mpp_q, mpp_d;
    logic [1:0] fs_q, fs_d;
    logic       mprv_q, mprv_d;
    logic       tw_q, tw_d;
    logic       illegal_wfi_q, illegal_wfi_d;
    wfi_state_e state_q, state_d;

    // Writable fields packed as {tw, mprv, fs, mpp, mpie, mie}.
    logic [7:0] fld_old;
    logic [7:0] fld_op;
    logic [7:0] fld_new;
    logic       csr_do;
    logic       wfi_trapped;

    logic unused_wdata;
    assign unused_wdata = ^{csr_wdata[63:22], csr_wdata[20:18],
                            csr_wdata[16:15], csr_wdata[10:8],
                            csr_wdata[6:4], csr_wdata[2:0]};

    assign fld_old = {tw_q, mprv_q, fs_q, mpp_q, mpie_q, mie_q};
    assign fld_op  = {csr_wdata[21], csr_wdata[17], csr_wdata[14:13],
                      csr_wdata[12:11], csr_wdata[7], csr_wdata[3]};
    assign csr_do  = csr_wen && (csr_cmd != 2'b00);

    always_comb begin
        fld_new = fld_old;
        unique case (csr_cmd)
            2'b01:   fld_new = fld_op;
            2'b10:   fld_new = fld_old | fld_op;
            2'b11:   fld_new = fld_old & ~fld_op;
            default: fld_new = fld_old;
        endcase
    end

    // Field update: trap beats MRET beats CSR access.
    always_comb begin
        prv_d  = prv_q;
        mie_d  = mie_q;
        mpie_d = mpie_q;
        mpp_d  = mpp_q;
        fs_d   = fs_q;
        mprv_d = mprv_q;
        tw_d   = tw_q;
        if (trap_valid) begin
            mpie_d = mie_q;
            mie_d  = 1'b0;
            mpp_d  = prv_q;
            prv_d  = PRV_M;
        end else if (mret_valid) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
            prv_d  = mpp_q;
            mpp_d  = PRV_U;
            if (mpp_q != PRV_M) begin
                mprv_d = 1'b0;
            end
        end else if (csr_do) begin
            mie_d  = fld_new[0];
            mpie_d = fld_new[1];
            fs_d   = fld_new[5:4];
            mprv_d = fld_new[6];
            tw_d   = fld_new[7];
            // MPP is WARL: unsupported S/H encodings keep the old value.
            if (fld_new[3:2] == PRV_M || fld_new[3:2] == PRV_U) begin
                mpp_d = fld_new[3:2];
            end
        end
        if (fs_dirty_set) begin
            fs_d = 2'b11;
        end
        if (!HAS_FPU) begin
            fs_d = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prv_q  <= PRV_M;
            mie_q  <= 1'b0;
            mpie_q <= 1'b0;
            mpp_q  <= PRV_M;
            fs_q   <= 2'b00;
            mprv_q <= 1'b0;
            tw_q   <= 1'b0;
        end else begin
            prv_q  <= prv_d;
            mie_q  <= mie_d;
            mpie_q <= mpie_d;
            mpp_q  <= mpp_d;
            fs_q   <= fs_d;
            mprv_q <= mprv_d;
            tw_q   <= tw_d;
        end
    end

    // A WFI in U-mode with TW set faults instead of sleeping.
    assign wfi_trapped = (prv_q == PRV_U) && tw_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            illegal_wfi_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            illegal_wfi_q <= illegal_wfi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (wfi_valid && !trap_valid && !wfi_trapped &&
                    !irq_pending) begin
                    state_d = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (irq_pending || trap_valid) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        illegal_wfi_d = 1'b0;
        if (state_q == ST_RUN) begin
            illegal_wfi_d = wfi_valid && !trap_valid && wfi_trapped;
        end
    end

    assign sleeping    = (state_q == ST_SLEEP);
    assign illegal_wfi = illegal_wfi_q;

    assign prv  = prv_q;
    assign mie  = mie_q;
    assign mpie = mpie_q;
    assign mpp  = mpp_q;
    assign fs   = fs_q;
    assign mprv = mprv_q;
    assign tw   = tw_q;
    assign sd   = (fs_q == 2'b11);
    assign dprv = mprv_q ? mpp_q : prv_q;

    // UXL reads as 2 (64-bit); XS is always off.
    always_comb begin
        mstatus_rdata        = '0;
        mstatus_rdata[3]     = mie_q;
        mstatus_rdata[7]     = mpie_q;
        mstatus_rdata[12:11] = mpp_q;
        mstatus_rdata[14:13] = fs_q;
        mstatus_rdata[17]    = mprv_q;
        mstatus_rdata[21]    = tw_q;
        mstatus_rdata[33:32] = 2'b10;
        mstatus_rdata[63]    = sd;
    end

endmodule

// File: doc/mstatus_csr_ctrl.md
MSTATUS_CSR_CTRL -- requirements
Module: mstatus_csr_ctrl

Interface
REQ-001 Parameter HAS_FPU, default 1; when 0, FS is hardwired to 2'b00 and fs_dirty_set is ignored.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 csr_wen  input  1  CSR access to mstatus retires this cycle.
REQ-005 csr_cmd  input  2  01=write, 10=set, 11=clear; 00=no-op even with csr_wen.
REQ-006 csr_wdata  input  64  operand for csr_cmd.
REQ-007 trap_valid  input  1  trap/interrupt taken this cycle.
REQ-008 mret_valid  input  1  MRET retires this cycle.
REQ-009 wfi_valid  input  1  WFI retires this cycle.
REQ-010 irq_pending  input  1  any enabled-or-pending interrupt (wakes WFI regardless of MIE).
REQ-011 fs_dirty_set  input  1  FP state written this cycle.
REQ-012 prv  output  2  current privilege, 11=M, 00=U.
REQ-013 dprv  output  2  effective data privilege.
REQ-014 mie, mpie, mprv, tw, sd  output  1 each  registered mstatus fields; sd is derived.
REQ-015 mpp, fs  output  2 each  registered mstatus fields.
REQ-016 mstatus_rdata  output  64  architectural read view.
REQ-017 sleeping  output  1  core is in WFI sleep.
REQ-018 illegal_wfi  output  1  one-cycle pulse when a WFI is illegal.

Function
REQ-019 Only M (11) and U (00) privileges exist; all field state SHALL update on the clock edge, so an event in cycle N is visible on the outputs in cycle N+1.
REQ-020 Per-cycle priority SHALL be trap_valid > mret_valid > csr_wen; lower-priority events in the same cycle are discarded.
REQ-021 Trap: MPIE<=MIE, MIE<=0, MPP<=prv, prv<=11; FS and MPRV unchanged.
REQ-022 MRET: MIE<=MPIE, MPIE<=1, prv<=MPP, MPP<=00, and MPRV<=0 when the old MPP!=11.
REQ-023 CSR write: new = wdata (01), old|wdata (10), or old&~wdata (11), applied to MIE[3], MPIE[7], MPP[12:11], FS[14:13], MPRV[17], TW[21]; all other bits are ignored.
REQ-024 MPP is WARL: a resulting value of 01 or 10 SHALL leave MPP unchanged.
REQ-025 fs_dirty_set (HAS_FPU=1) SHALL force FS=11 in the same update and override any same-cycle CSR-written FS value.
REQ-026 sd = (fs==11), combinational from registers; XS is read-only 00.
REQ-027 dprv = mprv ? mpp : prv.
REQ-028 mstatus_rdata: [3]=mie, [7]=mpie, [12:11]=mpp, [14:13]=fs, [16:15]=00, [17]=mprv, [21]=tw, [33:32]=10 (UXL), [63]=sd, all other bits 0; combinational from the registers.
REQ-029 WFI FSM has two states, RUN and SLEEP.
REQ-030 FSM, from RUN: wfi_valid with prv==00 and tw==1 SHALL assert illegal_wfi for one cycle and stay in RUN.
REQ-031 FSM, from RUN: any other wfi_valid with irq_pending==0 SHALL go to SLEEP; wfi_valid with irq_pending==1 SHALL stay in RUN.
REQ-032 FSM, from SLEEP: irq_pending or trap_valid SHALL return to RUN on the next edge.
REQ-033 sleeping = (state==SLEEP).
REQ-034 Simultaneous trap_valid and wfi_valid: the trap wins, the FSM stays in RUN and illegal_wfi stays 0.

Reset
REQ-035 While reset is high, and asynchronously on its assertion, the block SHALL hold: prv=11, mie=0, mpie=0, mpp=11, fs=00, mprv=0, tw=0, state=RUN, illegal_wfi=0.
REQ-036 Reset asserted mid-SLEEP or mid-event SHALL abandon the pending update and return to the REQ-035 values.

Verification
REQ-037 Reset release -> mstatus_rdata=0x0000_0002_0000_1800, prv=11, sleeping=0.
REQ-038 CSR set 0x8 in M; then trap with prv=11 -> next cycle mie=0, mpie=1, mpp=11, prv=11; then MRET -> mie=1, mpie=1, mpp=00, prv=11.
REQ-039 CSR write mpp=00 and mprv=1, then MRET -> prv=00, mprv=0, dprv=00; CSR write mpp=01 -> mpp stays at its prior value.
REQ-040 trap_valid, mret_valid and csr_wen(write 0) all in one cycle with mie=1 -> only trap effects are applied, mpie=1.
REQ-041 In U with tw=1, wfi_valid -> illegal_wfi pulses for 1 cycle and sleeping=0; with tw=0, wfi_valid and irq_pending=0 -> sleeping=1; irq_pending=1 -> sleeping=0 next cycle.
REQ-042 csr clear of FS with fs_dirty_set in the same cycle -> fs=11 and sd=1; with HAS_FPU=0 -> fs=00 and sd=0.
